arb_requester: RTL
==================

// Module: arb_requester
// PURPOSE
//   Initiator side of the request/grant bus shared via the 2-port arbiter.
//   Buffers locally produced words and raises request once a burst is ready.
//   After grant, drives the words onto the shared bus one per cycle, then drops request.
//   One instance sits in front of each arbiter port (request1/grant1, request2/grant2).
// PARAMETERS
//   DATA_W      8  bus/data word width
//   DEPTH       8  local FIFO depth in words; power of 2, >= 2
//   BURST_LEN   4  max words per grant tenure; 1..DEPTH
//   GAP_CYCLES  1  idle cycles after release before request may re-assert; 0..15
// PORTS
//   clk        in   1                         clock, all state on posedge
//   rst        in   1                         reset; asynchronous, active-low
//   wr_valid   in   1                         local word offered
//   wr_ready   out  1                         FIFO not full; push on wr_valid&&wr_ready
//   wr_data    in   DATA_W                    local word
//   flush      in   1                         pulse: send buffered words even if < BURST_LEN
//   request    out  1                         bus request to arbiter (registered)
//   grant      in   1                         grant from arbiter
//   bus_valid  out  1                         word on bus_data valid (registered)
//   bus_data   out  DATA_W                    bus word (registered)
//   bus_last   out  1                         final word of this tenure (registered)
//   busy       out  1                         state != IDLE or FIFO non-empty
// BEHAVIOUR
//   Reset (rst=0, async): request=0, bus_valid=0, bus_data=0, bus_last=0.
//   Reset also empties the FIFO, clears flush_pending and sets state=IDLE.
//   wr_ready=1 after reset. Reset mid-burst drops request immediately; buffered words are lost.
//   Accept rule: a bus word is transferred at a posedge with bus_valid=1 && grant=1.
//   FSM IDLE/REQ/XFER/GAP:
//   - IDLE: if count>=BURST_LEN, or flush_pending && count>0 -> REQ, request=1 at the same edge.
//     flush_pending is set by flush and cleared on entry to XFER.
//   - REQ: request held high.
//     At the edge where grant=1 -> XFER; bus_valid=1, bus_data=FIFO head at that edge.
//     nwords=min(BURST_LEN,count) is latched then. Grant-to-valid latency is 1 edge.
//   - XFER, edge with grant=1: head word accepted and popped; the next word is presented.
//     bus_last=1 while the presented word is the nwords-th.
//   - XFER, accepted word was the last one: request=0, bus_valid=0, bus_last=0.
//     Go to GAP, or to IDLE if GAP_CYCLES=0.
//   - XFER, edge with grant=0 (preemption): word not accepted and stays the FIFO head.
//     bus_valid=0 -> REQ with request still 1; resume with remaining nwords on regrant.
//   - GAP: count GAP_CYCLES edges with request=0, then IDLE.
//   - Pushes are allowed in every state. Push and pop at the same edge keep count unchanged.
//     Full FIFO: wr_ready=0. Pointers wrap modulo DEPTH.
//   - Words pushed during XFER are not added to the current tenure; nwords is fixed.
//   bus_data holds its last value when bus_valid=0; it is not forced to 0.
// STRUCTURE
//   Package arb_pkg: typedef enum logic[1:0] {IDLE,REQ,XFER,GAP} req_state_t;
//   arb_pkg also holds localparam CNT_W = $clog2(DEPTH)+1.
//   Sub-module sync_fifo #(DATA_W,DEPTH): push/pop, head, count, full, empty; async active-low rst.
//   Top level: FSM, nwords/sent counters, gap counter, output registers.
// TESTING
//   1. Push 4 words 0x11..0x14 with grant tied to request delayed 1 clk
//      -> request rises after 4th push.
//      bus_valid for 4 consecutive clks with 0x11..0x14; bus_last on 0x14; request falls same edge.
//   2. Push 2 words, no flush -> request stays 0 for 20 clks.
//      Pulse flush -> one tenure of 2 words, bus_last on the 2nd.
//   3. Mid-burst preemption: grant drops after 2 words accepted.
//      -> bus_valid=0 next edge, request stays 1.
//      On regrant words 3,4 sent with no duplicates or loss; bus_last on word 4.
//   4. Push 8 words (DEPTH=8) -> wr_ready=0 at count 8.
//      Two tenures of 4 follow, separated by exactly GAP_CYCLES=1 clk of request=0.
//   5. Assert rst=0 mid-XFER between clock edges -> request, bus_valid, bus_last go 0 immediately.
//      After release: busy=0, wr_ready=1.
//   6. Two instances plus the arbiter, both loaded with 4 words.
//      -> tenures never overlap; all 8 words are delivered in order per source.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the arbiter requester slice.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} req_state_t;

  localparam int DEF_DEPTH = 8;
  localparam int CNT_W     = $clog2(DEF_DEPTH) + 1;

  // Occupancy counters need one extra bit so "full" (== DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO exposing the head word and the word behind it,
// so the requester can present back-to-back bus words from registers.
module sync_fifo
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rstN,
  input  logic                          i_push,
  input  logic [DATA_W-1:0]             i_wrData,
  input  logic                          i_pop,
  output logic [DATA_W-1:0]             o_head,
  output logic [DATA_W-1:0]             o_head2,
  output logic [cnt_width(DEPTH)-1:0]   o_count,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_count;
  logic              w_doPush;
  logic              w_doPop;
  logic [AW-1:0]     w_rdPtr2;

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign w_rdPtr2 = r_rdPtr + 1'b1;

  assign o_head  = r_mem[r_rdPtr];
  assign o_head2 = r_mem[w_rdPtr2];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wrData;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Initiator side of the shared request/grant bus: buffers local words,
// requests the bus once a burst is ready and streams it out after grant.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              request,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              busy
);

  localparam int            CW         = cnt_width(DEPTH);
  localparam logic [CW-1:0] BURST      = CW'(BURST_LEN);
  localparam logic [3:0]    GAP_RELOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  req_state_t        r_state, w_stateNext;
  logic              r_request, r_busValid, r_busLast, r_flushPend, r_inTenure;
  logic [DATA_W-1:0] r_busData;
  logic [CW-1:0]     r_nwords, r_sent;
  logic [3:0]        r_gapCnt;

  logic              w_request, w_busValid, w_busLast, w_inTenure;
  logic [DATA_W-1:0] w_busData;
  logic [CW-1:0]     w_nwords, w_sent, w_sentInc, w_burstN;
  logic [3:0]        w_gapCnt;

  logic [DATA_W-1:0] w_head, w_head2;
  logic [CW-1:0]     w_count;
  logic              w_full, w_empty, w_accept, w_lastAccept, w_launch;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rstN  (rst),
    .i_push  (wr_valid),
    .i_wrData(wr_data),
    .i_pop   (w_accept),
    .o_head  (w_head),
    .o_head2 (w_head2),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // bus_valid is high for the whole of XFER, so grant alone marks an accepted word.
  assign w_accept     = (r_state == XFER) && grant;
  assign w_sentInc    = r_sent + 1'b1;
  assign w_lastAccept = w_accept && (w_sentInc == r_nwords);
  assign w_launch     = (w_count >= BURST) || (r_flushPend && !w_empty);
  assign w_burstN     = (w_count < BURST) ? w_count : BURST;

  assign wr_ready  = !w_full;
  assign busy      = (r_state != IDLE) || !w_empty;
  assign request   = r_request;
  assign bus_valid = r_busValid;
  assign bus_data  = r_busData;
  assign bus_last  = r_busLast;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_request   <= 1'b0;
      r_busValid  <= 1'b0;
      r_busData   <= '0;
      r_busLast   <= 1'b0;
      r_flushPend <= 1'b0;
      r_inTenure  <= 1'b0;
      r_nwords    <= '0;
      r_sent      <= '0;
      r_gapCnt    <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_request   <= w_request;
      r_busValid  <= w_busValid;
      r_busData   <= w_busData;
      r_busLast   <= w_busLast;
      r_inTenure  <= w_inTenure;
      r_nwords    <= w_nwords;
      r_sent      <= w_sent;
      r_gapCnt    <= w_gapCnt;
      r_flushPend <= flush || (r_flushPend && !(r_state == REQ && grant));
    end
  end

  // The final GAP edge doubles as an IDLE decision, so request stays low
  // for exactly GAP_CYCLES cycles between tenures.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (w_launch) w_stateNext = REQ;
      REQ:  if (grant) w_stateNext = XFER;
      XFER: begin
        if (!grant)            w_stateNext = REQ;
        else if (w_lastAccept) w_stateNext = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP:  if (r_gapCnt == 4'd0) w_stateNext = w_launch ? REQ : IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_request  = r_request;
    w_busValid = r_busValid;
    w_busData  = r_busData;
    w_busLast  = r_busLast;
    w_inTenure = r_inTenure;
    w_nwords   = r_nwords;
    w_sent     = r_sent;
    w_gapCnt   = r_gapCnt;
    case (r_state)
      IDLE: if (w_launch) w_request = 1'b1;
      REQ: begin
        if (grant) begin
          w_busValid = 1'b1;
          w_busData  = w_head;
          // A regrant after preemption resumes the tenure with its original length.
          if (!r_inTenure) begin
            w_inTenure = 1'b1;
            w_nwords   = w_burstN;
            w_sent     = '0;
            w_busLast  = (w_burstN == CW'(1));
          end else begin
            w_busLast  = (r_sent == r_nwords - 1'b1);
          end
        end
      end
      XFER: begin
        if (!grant) begin
          w_busValid = 1'b0;
          w_busLast  = 1'b0;
        end else if (w_lastAccept) begin
          w_request  = 1'b0;
          w_busValid = 1'b0;
          w_busLast  = 1'b0;
          w_inTenure = 1'b0;
          w_sent     = '0;
          w_gapCnt   = GAP_RELOAD;
        end else begin
          w_busData  = w_head2;
          w_sent     = w_sentInc;
          w_busLast  = (w_sentInc == r_nwords - 1'b1);
        end
      end
      GAP: begin
        if (r_gapCnt == 4'd0) begin
          if (w_launch) w_request = 1'b1;
        end else begin
          w_gapCnt = r_gapCnt - 1'b1;
        end
      end
      default: w_request = 1'b0;
    endcase
  end

endmodule
